timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
- Controls the oven's countdown timer.
- Accepts the decoded keypad digit stream from timer_controle (D, loadn) and shifts the digits into a 4-digit BCD MM:SS register.
- Arms and runs the countdown on start. Decrements once per pgt_1Hz pulse.
- Drives the magnetron enable and the keypad enablen. Handles pause, cancel and the end-of-cook alarm.

Parameters:
- ALARM_SECS, 3: number of pgt_1Hz ticks that alarm stays high after the count reaches 00:00.
- DEBOUNCE_CYC, 2: number of consecutive clk100 samples a startn or stopn level must hold before it is accepted.

Ports:
- clk100  in  1  system clock.
- clearn  in  1  asynchronous active-low reset.
- D  in  4  BCD digit from timer_controle. Valid on the cycle loadn falls.
- loadn  in  1  active-low digit strobe from timer_controle.
- pgt_1Hz  in  1  one-clk100-cycle pulse, once per second.
- startn  in  1  start button, active-low level.
- stopn  in  1  stop/cancel button, active-low level.
- door_closed  in  1  door interlock; 1 = closed.
- enablen  out  1  keypad enable to timer_controle, active-low.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  current time, BCD.
- mag_on  out  1  magnetron enable.
- alarm  out  1  end-of-cook alarm.
- done  out  1  one-cycle pulse on entry to ALARM.
- state_o  out  2  current FSM state, for display and debug.

Behaviour:
- Reset (clearn=0, asynchronous):
  - state=IDLE.
  - all digits 0.
  - mag_on=0, alarm=0, done=0, enablen=0.
  - debounce and edge-detect registers cleared.
- Button conditioning:
  - startn and stopn are debounced (DEBOUNCE_CYC samples).
  - A press is the debounced high-to-low edge; it produces a single internal pulse.
- Digit entry:
  - A falling edge of loadn (registered edge detect) is acted on only in IDLE, and only when D<=9.
  - Action: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D. The old min_tens is discarded.
  - D>9, or an edge outside IDLE, is ignored.
  - Latency: digits update 1 cycle after the sampled loadn falling edge.
- zero flag: all four digits equal 0.
- States (2-bit encoding): IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- IDLE:
  - enablen=0, mag_on=0.
  - stop press: clear all digits, stay in IDLE.
  - start press with door_closed=1 and zero=0: go to RUN.
  - start press with the door open or zero=1: ignored.
- RUN:
  - enablen=1, mag_on=1 (registered, asserted the cycle after entry).
  - On pgt_1Hz, decrement the BCD time:
    - sec_ones: 0 wraps to 9, otherwise -1.
    - sec_tens: borrows when sec_ones wraps; 0 wraps to 5.
    - Minutes borrow when the seconds field wraps from 00 to 59.
    - Entered seconds values >59 (e.g. 01:90) count down natively to :00 before borrowing.
  - If the decrement result is 00:00, go to ALARM in the same update.
  - door_closed=0, or a stop press: go to PAUSE. The time is held, and a pgt_1Hz in that same cycle is not applied.
- PAUSE:
  - mag_on=0, enablen=1.
  - start press with door_closed=1: return to RUN.
  - stop press: clear digits, go to IDLE.
- ALARM:
  - alarm=1, done=1 for exactly the entry cycle, mag_on=0, enablen=1.
  - After ALARM_SECS pgt_1Hz pulses, or on a stop press, go to IDLE with alarm=0.
- Priority within a cycle: clearn > stop > door open > start > pgt_1Hz > loadn.
- mag_on must never be 1 while door_closed=0 for more than 1 cycle.

Decomposition:
- Package timer_seq_pkg holds:
  - the state encodings (IDLE/RUN/PAUSE/ALARM);
  - the BCD constants (BCD_NINE=9, SEC_TENS_MAX=5);
  - the width constant DIGIT_W=4.
- Sub-module mmss_bcd_counter holds the four digit registers. Inputs: shift_en, shift_digit, dec_en, clr. Outputs: the digits and zero. The FSM stays in timer_sequencer.

Test Plan:
- Reset, then loadn strobes with D=1,2,3,0 in IDLE -> digits 12:30. enablen=0, state_o=0.
- Load 00:02, door_closed=1, start press -> RUN, mag_on=1. After pgt_1Hz: 00:01. After a second pgt_1Hz: 00:00, state ALARM, done pulses one cycle, alarm=1. After 3 more pgt_1Hz: IDLE, alarm=0.
- Load 01:00, start, one pgt_1Hz -> 00:59. Load 00:90, start, one pgt_1Hz -> 00:89.
- In RUN at 00:45, drop door_closed while pgt_1Hz is high -> PAUSE, time stays 00:45, mag_on=0 next cycle. Close the door, start press -> RUN resumes.
- Start press with zero=1, or with the door open, -> stays IDLE. loadn with D=12 -> digits unchanged. loadn during RUN -> digits unchanged.
- Assert clearn=0 mid-RUN at 03:17 -> immediately IDLE, 00:00, mag_on=0. Stop press in PAUSE -> IDLE, 00:00.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the oven countdown timer.
// State encodings, BCD limits and the digit width.
package timer_seq_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_NINE     = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

endpackage

// File: rtl/mmss_bcd_counter.sv
// Four-digit MM:SS BCD register with shift-in entry and countdown.
// Ports: clk/rst_n, shift_en+shift_digit (keypad), dec_en (1 s tick),
// clr (zero all), digit outputs, zero and last_sec (value is 00:01).
import timer_seq_pkg::*;

module mmss_bcd_counter (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic [DIGIT_W-1:0] shift_digit,
  input  logic               dec_en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               zero,
  output logic               last_sec
);

  localparam logic [DIGIT_W-1:0] ONE = DIGIT_W'(1);

  logic [DIGIT_W-1:0] so_d, st_d, mo_d, mt_d;
  logic               b0, b1, b2;

  // Ripple borrow; seconds tens wraps to 5 so 01:90 counts
  // through :89..:00 before the minutes borrow.
  always_comb begin
    b0   = (sec_ones == '0);
    b1   = 1'b0;
    b2   = 1'b0;
    so_d = b0 ? BCD_NINE : sec_ones - ONE;
    st_d = sec_tens;
    mo_d = min_ones;
    mt_d = min_tens;
    if (b0) begin
      if (sec_tens == '0) begin
        st_d = SEC_TENS_MAX;
        b1   = 1'b1;
      end else begin
        st_d = sec_tens - ONE;
      end
    end
    if (b1) begin
      if (min_ones == '0) begin
        mo_d = BCD_NINE;
        b2   = 1'b1;
      end else begin
        mo_d = min_ones - ONE;
      end
    end
    if (b2) begin
      mt_d = (min_tens == '0) ? BCD_NINE
                              : min_tens - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (clr) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (shift_en) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= shift_digit;
    end else if (dec_en) begin
      min_tens <= mt_d;
      min_ones <= mo_d;
      sec_tens <= st_d;
      sec_ones <= so_d;
    end
  end

  assign zero = (min_tens == '0) && (min_ones == '0)
             && (sec_tens == '0) && (sec_ones == '0);

  assign last_sec = (min_tens == '0) && (min_ones == '0)
                 && (sec_tens == '0) && (sec_ones == ONE);

endmodule

// File: rtl/timer_sequencer.sv
// Oven countdown sequencer: keypad entry, run/pause/alarm FSM.
// Ports: clk100/clearn, D+loadn keypad, pgt_1Hz, startn/stopn,
// door_closed; enablen, MM:SS digits, mag_on, alarm, done, state_o.
import timer_seq_pkg::*;

module timer_sequencer #(
  parameter int ALARM_SECS   = 3,
  parameter int DEBOUNCE_CYC = 2
) (
  input  logic               clk100,
  input  logic               clearn,
  input  logic [DIGIT_W-1:0] D,
  input  logic               loadn,
  input  logic               pgt_1Hz,
  input  logic               startn,
  input  logic               stopn,
  input  logic               door_closed,
  output logic               enablen,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               mag_on,
  output logic               alarm,
  output logic               done,
  output logic [1:0]         state_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int AW = $clog2(ALARM_SECS + 1);

  state_t        state, state_n;
  logic          loadn_q, ld_fall;
  logic [1:0]    btn_raw, btn_press;
  logic          start_p, stop_p;
  logic [AW-1:0] alarm_cnt;
  logic          shift_en, dec_en, clr;
  logic          zero, last_sec;

  assign btn_raw = {stopn, startn};

  // A level is accepted after DEBOUNCE_CYC consecutive samples
  // that disagree with the current accepted level.
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic [CW-1:0] cnt;
    logic          db, db_q;

    always_ff @(posedge clk100 or negedge clearn) begin
      if (!clearn) begin
        cnt  <= '0;
        db   <= 1'b0;
        db_q <= 1'b0;
      end else begin
        db_q <= db;
        if (btn_raw[g] != db) begin
          if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            db  <= btn_raw[g];
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign btn_press[g] = db_q & ~db;
  end

  assign start_p = btn_press[0];
  assign stop_p  = btn_press[1];
  assign ld_fall = loadn_q & ~loadn;

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    dec_en   = 1'b0;
    clr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (stop_p) begin
          clr = 1'b1;
        end else if (start_p && door_closed && !zero) begin
          state_n = RUN;
        end else if (ld_fall && (D <= BCD_NINE)) begin
          shift_en = 1'b1;
        end
      end
      RUN: begin
        if (stop_p || !door_closed) begin
          state_n = PAUSE;
        end else if (pgt_1Hz) begin
          dec_en = 1'b1;
          if (last_sec) state_n = ALARM;
        end
      end
      PAUSE: begin
        if (stop_p) begin
          clr     = 1'b1;
          state_n = IDLE;
        end else if (start_p && door_closed) begin
          state_n = RUN;
        end
      end
      ALARM: begin
        if (stop_p) begin
          state_n = IDLE;
        end else if (pgt_1Hz
                  && alarm_cnt == AW'(ALARM_SECS - 1)) begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk100 or negedge clearn) begin
    if (!clearn) begin
      state     <= IDLE;
      loadn_q   <= 1'b0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      state   <= state_n;
      loadn_q <= loadn;
      // Dropping in the same edge the FSM leaves RUN keeps
      // the magnetron off as soon as the door opens.
      mag_on  <= (state == RUN) && (state_n == RUN);
      done    <= (state_n == ALARM) && (state != ALARM);
      if (state != ALARM) begin
        alarm_cnt <= '0;
      end else if (pgt_1Hz) begin
        alarm_cnt <= alarm_cnt + AW'(1);
      end
    end
  end

  mmss_bcd_counter u_cnt (
    .clk         (clk100),
    .rst_n       (clearn),
    .shift_en    (shift_en),
    .shift_digit (D),
    .dec_en      (dec_en),
    .clr         (clr),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .zero        (zero),
    .last_sec    (last_sec)
  );

  assign enablen = (state != IDLE);
  assign alarm   = (state == ALARM);
  assign state_o = state;

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer.
// Stimulus queues expectations; a negedge monitor pops and compares.
`timescale 1ns/1ps
import timer_seq_pkg::*;

module tb_timer_sequencer;

  logic       clk100 = 1'b0;
  logic       clearn;
  logic [3:0] D;
  logic       loadn, pgt_1Hz, startn, stopn, door_closed;
  logic       enablen, mag_on, alarm, done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [15:0] t;
    logic        mag, alm, en, dn;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk100 = ~clk100;

  timer_sequencer dut (
    .clk100      (clk100),
    .clearn      (clearn),
    .D           (D),
    .loadn       (loadn),
    .pgt_1Hz     (pgt_1Hz),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .enablen     (enablen),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .mag_on      (mag_on),
    .alarm       (alarm),
    .done        (done),
    .state_o     (state_o)
  );

  wire [15:0] t_now = {min_tens, min_ones, sec_tens, sec_ones};

  always @(negedge clk100) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (state_o !== e.st || t_now !== e.t || mag_on !== e.mag
          || alarm !== e.alm || enablen !== e.en
          || done !== e.dn) begin
        errors++;
        $display("FAIL %s: got st=%0d t=%h mag=%b alm=%b en=%b dn=%b, want st=%0d t=%h mag=%b alm=%b en=%b dn=%b",
                 e.name, state_o, t_now, mag_on, alarm, enablen,
                 done, e.st, e.t, e.mag, e.alm, e.en, e.dn);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic expect_now(input string name,
                            input logic [1:0] st,
                            input logic [15:0] t,
                            input logic mag, input logic alm,
                            input logic en, input logic dn);
    exp_t x;
    x.name = name; x.st = st; x.t = t;
    x.mag = mag; x.alm = alm; x.en = en; x.dn = dn;
    sb.push_back(x);
    @(negedge clk100);
    #1;
  endtask

  task automatic load(input logic [3:0] d);
    D = d;
    loadn = 1'b0;
    tick(1);
    loadn = 1'b1;
    tick(1);
  endtask

  task automatic press_start;
    startn = 1'b0;
    tick(4);
    startn = 1'b1;
    tick(4);
  endtask

  task automatic press_stop;
    stopn = 1'b0;
    tick(4);
    stopn = 1'b1;
    tick(4);
  endtask

  task automatic pulse;
    pgt_1Hz = 1'b1;
    tick(1);
    pgt_1Hz = 1'b0;
  endtask

  initial begin
    clearn = 1'b0; loadn = 1'b1; startn = 1'b1; stopn = 1'b1;
    door_closed = 1'b1; pgt_1Hz = 1'b0; D = '0;
    tick(2);
    expect_now("reset", IDLE, 16'h0000, 0, 0, 0, 0);
    clearn = 1'b1;
    tick(4);

    load(1); load(2); load(3); load(0);
    expect_now("load_1230", IDLE, 16'h1230, 0, 0, 0, 0);
    load(4'd12);
    expect_now("load_d12_ignored", IDLE, 16'h1230, 0, 0, 0, 0);
    press_stop;
    expect_now("idle_stop_clear", IDLE, 16'h0000, 0, 0, 0, 0);
    press_start;
    expect_now("start_zero_ignored", IDLE, 16'h0000, 0, 0, 0, 0);

    load(0); load(2);
    door_closed = 1'b0;
    press_start;
    expect_now("start_door_open", IDLE, 16'h0002, 0, 0, 0, 0);
    door_closed = 1'b1;
    press_start;
    expect_now("run_0002", RUN, 16'h0002, 1, 0, 1, 0);
    pulse;
    expect_now("run_0001", RUN, 16'h0001, 1, 0, 1, 0);
    pulse;
    expect_now("alarm_entry", ALARM, 16'h0000, 0, 1, 1, 1);
    tick(1);
    expect_now("alarm_hold", ALARM, 16'h0000, 0, 1, 1, 0);
    pulse; tick(2);
    pulse; tick(2);
    expect_now("alarm_after_2", ALARM, 16'h0000, 0, 1, 1, 0);
    pulse;
    expect_now("alarm_exit", IDLE, 16'h0000, 0, 0, 0, 0);

    load(1); load(0); load(0);
    press_start;
    pulse;
    expect_now("borrow_0059", RUN, 16'h0059, 1, 0, 1, 0);
    press_stop;
    expect_now("run_stop_pause", PAUSE, 16'h0059, 0, 0, 1, 0);
    press_stop;
    expect_now("pause_stop_idle", IDLE, 16'h0000, 0, 0, 0, 0);

    load(9); load(0);
    press_start;
    pulse;
    expect_now("native_0089", RUN, 16'h0089, 1, 0, 1, 0);
    load(5);
    expect_now("load_in_run", RUN, 16'h0089, 1, 0, 1, 0);
    press_stop; press_stop;

    load(4); load(5);
    press_start;
    expect_now("run_0045", RUN, 16'h0045, 1, 0, 1, 0);
    door_closed = 1'b0;
    pgt_1Hz = 1'b1;
    tick(1);
    pgt_1Hz = 1'b0;
    expect_now("door_pause", PAUSE, 16'h0045, 0, 0, 1, 0);
    door_closed = 1'b1;
    press_start;
    expect_now("resume_run", RUN, 16'h0045, 1, 0, 1, 0);
    press_stop; press_stop;

    load(3); load(1); load(7);
    press_start;
    expect_now("run_0317", RUN, 16'h0317, 1, 0, 1, 0);
    clearn = 1'b0;
    #1;
    expect_now("async_clear", IDLE, 16'h0000, 0, 0, 0, 0);
    clearn = 1'b1;
    tick(4);

    tick(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
